// File: rtl/pio_in_edge.sv
// pio_in_edge: Avalon-MM input port with synchroniser, per-bit edge capture,
// masked level interrupt and write-to-clear capture register.
module pio_in_edge #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    SYNC_STAGES  = 2,
  parameter int                    EDGE_TYPE    = 0,
  parameter int                    BIT_CLEARING = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int CW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
  logic [DATA_WIDTH-1:0]                  r_prev;
  logic [DATA_WIDTH-1:0]                  r_edgecap;
  logic [DATA_WIDTH-1:0]                  r_irqmask;
  logic [CW-1:0]                          r_prime_cnt;
  logic                                   r_primed;

  logic [DATA_WIDTH-1:0] w_sync;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_det;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] w_edgecap_nxt;
  logic [DATA_WIDTH-1:0] w_irqmask_nxt;
  logic [31:0]           w_rd;
  logic                  w_wr;
  logic                  w_wr_mask;
  logic                  w_wr_ecap;
  logic                  w_unused;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_wdata   = writedata[DATA_WIDTH-1:0];
  assign w_unused  = ^writedata;
  assign w_wr      = chipselect & ~write_n;
  assign w_wr_mask = w_wr & (address == 2'd2);
  assign w_wr_ecap = w_wr & (address == 2'd3);

  // Input synchroniser chain plus one-cycle delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync;
    end
  end

  // Hold off edge detection until the chain and prev hold real input values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prime_cnt <= '0;
      r_primed    <= 1'b0;
    end else if (!r_primed) begin
      if (r_prime_cnt == CW'(SYNC_STAGES)) r_primed <= 1'b1;
      else                                 r_prime_cnt <= r_prime_cnt + 1'b1;
    end
  end

  // Edge select, clear mask and next-state values for capture and mask
  always_comb begin
    w_det = '0;
    if (r_primed) begin
      case (EDGE_TYPE)
        0:       w_det = w_sync & ~r_prev;
        1:       w_det = ~w_sync & r_prev;
        default: w_det = w_sync ^ r_prev;
      endcase
    end
    w_clr = '0;
    if (w_wr_ecap) w_clr = (BIT_CLEARING == 1) ? w_wdata : '1;
    // set beats clear on the same bit
    w_edgecap_nxt = (r_edgecap & ~w_clr) | w_det;
    w_irqmask_nxt = w_wr_mask ? w_wdata : r_irqmask;
  end

  // Register read mux, zero-extended; reserved address reads 0
  always_comb begin
    w_rd = '0;
    case (address)
      2'd0:    w_rd[DATA_WIDTH-1:0] = w_sync;
      2'd2:    w_rd[DATA_WIDTH-1:0] = r_irqmask;
      2'd3:    w_rd[DATA_WIDTH-1:0] = r_edgecap;
      default: w_rd = '0;
    endcase
  end

  // Capture, mask, interrupt and read data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edgecap <= '0;
      r_irqmask <= RESET_VALUE;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      r_edgecap <= w_edgecap_nxt;
      r_irqmask <= w_irqmask_nxt;
      irq       <= |(w_edgecap_nxt & w_irqmask_nxt);
      readdata  <= w_rd;
    end
  end

endmodule

// File: tb/tb_pio_in_edge.sv
// Directed bench: dut0 = rising edge / bit clearing, dut1 = any edge /
// clear-all with a non-zero mask reset value. Bus and reset are shared.
module tb_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_port0 = 8'h00;
  logic [7:0]  in_port1 = 8'h00;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pio_in_edge dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port0),
    .readdata(rd0), .irq(irq0)
  );

  pio_in_edge #(.EDGE_TYPE(2), .BIT_CLEARING(0), .RESET_VALUE(8'hA0)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port1),
    .readdata(rd1), .irq(irq1)
  );

  // All tasks are entered and left at a falling clock edge.
  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; in_port0 = 8'hFF; in_port1 = 8'hFF; address = 2'd3;
    waitn(3);
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL rst_readdata act=%h exp=%h", rd0, 32'h0); end
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL rst_irq act=%b exp=0", irq0); end
    reset = 1'b0;
    waitn(10);
    rd(2'd0);
    n_tests++; if (rd0 !== 32'hFF) begin n_fail++; $display("FAIL rst_data0 act=%h exp=%h", rd0, 32'hFF); end
    n_tests++; if (rd1 !== 32'hFF) begin n_fail++; $display("FAIL rst_data1 act=%h exp=%h", rd1, 32'hFF); end
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL prime_ecap0 act=%h exp=%h", rd0, 32'h0); end
    n_tests++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL prime_ecap1 act=%h exp=%h", rd1, 32'h0); end
    n_tests++; if (irq0 !== 1'b0 || irq1 !== 1'b0) begin n_fail++; $display("FAIL prime_irq act=%b%b exp=00", irq0, irq1); end
    rd(2'd2);
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL rst_mask0 act=%h exp=%h", rd0, 32'h0); end
    n_tests++; if (rd1 !== 32'hA0) begin n_fail++; $display("FAIL rst_mask1 act=%h exp=%h", rd1, 32'hA0); end
  endtask

  task automatic test_rise;
    in_port0 = 8'h00;
    waitn(4);
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL fall_ignored act=%h exp=%h", rd0, 32'h0); end
    wr(2'd2, 32'h01);
    in_port0 = 8'h01;
    waitn(2);
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL rise_irq_early act=%b exp=0", irq0); end
    waitn(1);
    n_tests++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL rise_irq act=%b exp=1", irq0); end
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h01) begin n_fail++; $display("FAIL rise_ecap act=%h exp=%h", rd0, 32'h01); end
    in_port0 = 8'h00;
    waitn(4);
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h01) begin n_fail++; $display("FAIL rise_fall_hold act=%h exp=%h", rd0, 32'h01); end
  endtask

  task automatic test_bit_clear;
    in_port0 = 8'h05;
    waitn(4);
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h05) begin n_fail++; $display("FAIL bc_set act=%h exp=%h", rd0, 32'h05); end
    wr(2'd3, 32'h04);
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h01) begin n_fail++; $display("FAIL bc_clr4 act=%h exp=%h", rd0, 32'h01); end
    n_tests++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL bc_irq_hold act=%b exp=1", irq0); end
    wr(2'd3, 32'h01);
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL bc_irq_drop act=%b exp=0", irq0); end
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL bc_clr1 act=%h exp=%h", rd0, 32'h0); end
  endtask

  task automatic test_set_wins;
    in_port0 = 8'h04; waitn(4);
    in_port0 = 8'h05; waitn(4);
    in_port0 = 8'h04; waitn(4);
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h01) begin n_fail++; $display("FAIL sw_pre act=%h exp=%h", rd0, 32'h01); end
    in_port0 = 8'h05;
    waitn(2);
    wr(2'd3, 32'h01);
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h01) begin n_fail++; $display("FAIL set_wins act=%h exp=%h", rd0, 32'h01); end
    n_tests++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq act=%b exp=1", irq0); end
    wr(2'd3, 32'h01);
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL sw_clean act=%h exp=%h", rd0, 32'h0); end
  endtask

  task automatic test_any_edge;
    wr(2'd2, 32'h00);
    in_port1 = 8'h00;
    waitn(4);
    rd(2'd3);
    n_tests++; if (rd1 !== 32'hFF) begin n_fail++; $display("FAIL any_fall act=%h exp=%h", rd1, 32'hFF); end
    n_tests++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL any_irq_masked act=%b exp=0", irq1); end
    wr(2'd3, 32'h00);
    rd(2'd3);
    n_tests++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL clrall1 act=%h exp=%h", rd1, 32'h0); end
    in_port1 = 8'h08; waitn(4);
    in_port1 = 8'h00; waitn(4);
    rd(2'd3);
    n_tests++; if (rd1 !== 32'h08) begin n_fail++; $display("FAIL any_pulse act=%h exp=%h", rd1, 32'h08); end
    n_tests++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL any_pulse_irq act=%b exp=0", irq1); end
    wr(2'd3, 32'h00);
    rd(2'd3);
    n_tests++; if (rd1 !== 32'h0) begin n_fail++; $display("FAIL clrall2 act=%h exp=%h", rd1, 32'h0); end
  endtask

  task automatic test_reserved;
    wr(2'd1, 32'h55);
    wr(2'd0, 32'hAA);
    rd(2'd1);
    n_tests++; if (rd0 !== 32'h0 || rd1 !== 32'h0) begin n_fail++; $display("FAIL reserved act=%h/%h exp=0/0", rd0, rd1); end
    rd(2'd0);
    n_tests++; if (rd0 !== 32'h05) begin n_fail++; $display("FAIL data_ro act=%h exp=%h", rd0, 32'h05); end
  endtask

  task automatic test_latency;
    address = 2'd0;
    @(negedge clk);
    in_port0 = 8'h85;
    waitn(2);
    n_tests++; if (rd0 !== 32'h05) begin n_fail++; $display("FAIL lat_early act=%h exp=%h", rd0, 32'h05); end
    waitn(1);
    n_tests++; if (rd0 !== 32'h85) begin n_fail++; $display("FAIL lat_data act=%h exp=%h", rd0, 32'h85); end
  endtask

  task automatic test_reset_mid;
    wr(2'd2, 32'hFF);
    rd(2'd3);
    n_tests++; if (irq0 !== 1'b1 || rd0 !== 32'h80) begin n_fail++; $display("FAIL pre_rst act=%b/%h exp=1/%h", irq0, rd0, 32'h80); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq act=%b exp=0", irq0); end
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_rd act=%h exp=%h", rd0, 32'h0); end
    @(negedge clk);
    reset = 1'b0;
    waitn(10);
    rd(2'd2);
    n_tests++; if (rd0 !== 32'h0 || rd1 !== 32'hA0) begin n_fail++; $display("FAIL mid_rst_mask act=%h/%h exp=0/a0", rd0, rd1); end
    rd(2'd3);
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_ecap act=%h exp=%h", rd0, 32'h0); end
    n_tests++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_prime_irq act=%b exp=0", irq0); end
    rd(2'd1);
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_res act=%h exp=%h", rd0, 32'h0); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_rise;
    test_bit_clear;
    test_set_wins;
    test_any_edge;
    test_reserved;
    test_latency;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
